// File: rtl/dp_sequencer.sv
// dp_sequencer -- multi-cycle control FSM for the 32-bit processor datapath.
//
// Fetches one instruction per pass over a Valid-handshaked memory bus,
// latches it in an internal IR, decodes it and sequences the datapath
// strobes for ALU, load/store, branch (with optional link) and HALT.
// A wait counter flags a bus error if Valid does not arrive in time.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   instr, Valid        memory data bus and handshake
//   mem_rd, mem_wr      memory read / write requests
//   opcode, oppA, oppB  ALU opcode and register indices to the datapath
//   literal             IR[15:0] sign-extended
//   regEn ... PCEn      datapath strobes
//   halted, bus_err     HALT executed / Valid timeout occurred
//
// state   | meaning
// FETCH_A | drive PC onto address register
// FETCH_W | read request, wait for Valid, latch IR
// INC     | increment PC
// DECODE  | one idle cycle, branch on instruction class
// EXEC    | ALU operation (reg-reg or immediate)
// WB      | register write-back
// MADDR   | compute memory address (base + literal)
// LOAD_W  | read request, wait for Valid
// SDATA   | pass reg B to data register
// STORE_W | write request, wait for Valid
// LINK    | reg[A] <= PC
// BR      | PC + literal through ALU
// BR_LD   | load new PC
// HALT    | halted, held until reset
// ERR     | bus timeout, held until reset

module dp_sequencer #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] instr,
    input  logic             Valid,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [5:0]       opcode,
    output logic [4:0]       oppA,
    output logic [4:0]       oppB,
    output logic [WIDTH-1:0] literal,
    output logic             regEn,
    output logic             increment,
    output logic             Branch_En,
    output logic             fetch,
    output logic             DataBus_En,
    output logic             store_en,
    output logic             wrData,
    output logic             wrAdd,
    output logic             store_PC,
    output logic             literalEn,
    output logic             PCEn,
    output logic             halted,
    output logic             bus_err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [3:0] {
        S_FETCH_A, S_FETCH_W, S_INC, S_DECODE, S_EXEC, S_WB, S_MADDR,
        S_LOAD_W, S_SDATA, S_STORE_W, S_LINK, S_BR, S_BR_LD, S_HALT, S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [5:0] ir_op;
    logic [1:0] ir_class;
    logic       is_halt;
    logic       timed_out;

    assign ir_op     = ir_q[31:26];
    assign ir_class  = ir_q[31:30];
    assign is_halt   = (ir_op == 6'h3F);
    // Valid has priority: only a cycle without Valid can expire the wait.
    assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_LAST) && !Valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH_A;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state. The counter is held at zero outside the wait states, so it
    // is already clear on entry to each of them.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cnt_d   = '0;
        case (state_q)
            S_FETCH_A: state_d = S_FETCH_W;
            S_FETCH_W: begin
                if (Valid) begin
                    ir_d    = instr;
                    state_d = S_INC;
                end else if (timed_out) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_INC: state_d = S_DECODE;
            S_DECODE: begin
                if (is_halt)                                  state_d = S_HALT;
                else if (ir_class == 2'b00 || ir_class == 2'b11) state_d = S_EXEC;
                else if (ir_class == 2'b10)                   state_d = S_MADDR;
                else if (ir_q[26])                            state_d = S_LINK;
                else                                          state_d = S_BR;
            end
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_FETCH_A;
            S_MADDR: state_d = ir_q[26] ? S_SDATA : S_LOAD_W;
            S_LOAD_W: begin
                if (Valid)          state_d = S_WB;
                else if (timed_out) state_d = S_ERR;
                else                cnt_d = cnt_q + CW'(1);
            end
            S_SDATA: state_d = S_STORE_W;
            S_STORE_W: begin
                if (Valid)          state_d = S_FETCH_A;
                else if (timed_out) state_d = S_ERR;
                else                cnt_d = cnt_q + CW'(1);
            end
            S_LINK:  state_d = S_BR;
            S_BR:    state_d = S_BR_LD;
            S_BR_LD: state_d = S_FETCH_A;
            S_HALT:  state_d = S_HALT;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_FETCH_A;
        endcase
    end

    // Moore outputs from state and IR; wrData in LOAD_W follows Valid so the
    // data register captures the bus in the cycle the read completes.
    // Everything is masked while reset is asserted so no request escapes.
    always_comb begin
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        opcode     = 6'h00;
        oppA       = ir_q[25:21];
        oppB       = ir_q[20:16];
        literal    = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};
        regEn      = 1'b0;
        increment  = 1'b0;
        Branch_En  = 1'b0;
        fetch      = 1'b0;
        DataBus_En = 1'b0;
        store_en   = 1'b0;
        wrData     = 1'b0;
        wrAdd      = 1'b0;
        store_PC   = 1'b0;
        literalEn  = 1'b0;
        PCEn       = 1'b0;
        halted     = 1'b0;
        bus_err    = 1'b0;
        case (state_q)
            S_FETCH_A: begin
                fetch = 1'b1;
                wrAdd = 1'b1;
            end
            S_FETCH_W: mem_rd = 1'b1;
            S_INC: begin
                increment = 1'b1;
                PCEn      = 1'b1;
            end
            S_EXEC: begin
                opcode    = ir_op;
                literalEn = (ir_class == 2'b11);
                wrData    = 1'b1;
            end
            S_WB: regEn = 1'b1;
            S_MADDR: begin
                literalEn = 1'b1;
                wrAdd     = 1'b1;
            end
            S_LOAD_W: begin
                mem_rd   = 1'b1;
                store_en = 1'b1;
                wrData   = Valid;
            end
            S_SDATA: begin
                opcode = 6'h0F;
                wrData = 1'b1;
            end
            S_STORE_W: begin
                DataBus_En = 1'b1;
                mem_wr     = 1'b1;
            end
            S_LINK: begin
                store_PC = 1'b1;
                regEn    = 1'b1;
            end
            S_BR: begin
                Branch_En = 1'b1;
                literalEn = 1'b1;
                opcode    = ir_op;
                wrData    = 1'b1;
            end
            S_BR_LD: PCEn    = 1'b1;
            S_HALT:  halted  = 1'b1;
            S_ERR:   bus_err = 1'b1;
            default: ;
        endcase
        if (reset) begin
            mem_rd     = 1'b0;
            mem_wr     = 1'b0;
            opcode     = 6'h00;
            oppA       = 5'd0;
            oppB       = 5'd0;
            literal    = '0;
            regEn      = 1'b0;
            increment  = 1'b0;
            Branch_En  = 1'b0;
            fetch      = 1'b0;
            DataBus_En = 1'b0;
            store_en   = 1'b0;
            wrData     = 1'b0;
            wrAdd      = 1'b0;
            store_PC   = 1'b0;
            literalEn  = 1'b0;
            PCEn       = 1'b0;
            halted     = 1'b0;
            bus_err    = 1'b0;
        end
    end

endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
Multi-cycle control FSM for the 32-bit processor datapath (reg file, ALU, PC, data/address registers, literal two's-complement unit).
- Fetches one instruction per pass over a valid-handshaked memory bus and latches it in an internal IR.
- Decodes the IR into opcode/oppA/oppB/literal fields.
- Sequences every datapath strobe for ALU, load/store, branch and halt instructions.
- Detects memory-bus timeouts.
- Sits between the memory bus and the datapath control inputs.

Parameters:
WIDTH, 32, data/instruction width
TIMEOUT, 255, max cycles waiting for Valid before bus error; 0 disables timeout

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
instr  in  WIDTH  memory data bus (instruction fetch source)
Valid  in  1  memory handshake: read data present / write accepted
mem_rd  out  1  memory read request
mem_wr  out  1  memory write request
opcode  out  6  ALU/class opcode to datapath
oppA  out  5  reg A / write-back index (IR[25:21])
oppB  out  5  reg B index (IR[20:16])
literal  out  WIDTH  IR[15:0] sign-extended
regEn, increment, Branch_En, fetch, DataBus_En, store_en, wrData, wrAdd, store_PC, literalEn, PCEn  out  1 each  datapath strobes
halted  out  1  HALT executed
bus_err  out  1  Valid timeout occurred

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset response: IR=0, wait counter=0, state=FETCH_A. All strobes, mem_rd, mem_wr, halted and bus_err are 0. opcode, oppA, oppB and literal are 0.
- Output timing: outputs are Moore-decoded from state and IR. A strobe not listed for a state is 0.
- IR fields: [31:26] opcode, [25:21] A, [20:16] B, [15:0] imm.
- Opcode classes (IR[31:30]): 00 ALU reg-reg; 11 ALU immediate; 10 memory (IR[26]=0 load, 1 store); 01 branch (IR[26]=1 link). IR[31:26]=6'h3F is HALT and takes priority over class decode.
- FETCH_A: fetch=1, wrAdd=1 -> FETCH_W.
- FETCH_W: mem_rd=1. On Valid: IR<=instr -> INC.
- INC: increment=1, PCEn=1 -> DECODE.
- DECODE (1 cycle, no strobes): HALT->HALT; 00/11->EXEC; 10->MADDR; 01 with link->LINK; 01 without link->BR.
- EXEC: opcode=IR[31:26], literalEn=(class==11), store_en=0, wrData=1 -> WB.
- WB: regEn=1, store_PC=0 -> FETCH_A.
- MADDR: opcode=6'h00 (add), literalEn=1, fetch=0, wrAdd=1. Load -> LOAD_W; store -> SDATA.
- LOAD_W: mem_rd=1, store_en=1, wrData=Valid. On Valid -> WB.
- SDATA: opcode=6'h0F (pass B), literalEn=0, wrData=1 -> STORE_W.
- STORE_W: DataBus_En=1, mem_wr=1. On Valid -> FETCH_A.
- LINK: store_PC=1, regEn=1 (reg[A]<=PC, already incremented) -> BR.
- BR: Branch_En=1, literalEn=1, opcode=IR[31:26] (ALU add/sub chosen by literal sign), wrData=1 -> BR_LD.
- BR_LD: store_PC=0, PCEn=1 -> FETCH_A.
- HALT: halted=1. Held until reset.
- Wait counter and timeout:
  - The counter clears on entry to each wait state (FETCH_W, LOAD_W, STORE_W) and increments each cycle without Valid.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT with Valid still low -> ERR.
  - Valid wins if it arrives in the same cycle the counter reaches TIMEOUT.
  - ERR: bus_err=1, all strobes 0. Held until reset.
- Valid outside the wait states is ignored.
- Reset asserted in any state, including mid-wait, returns to FETCH_A next cycle with all outputs cleared and no memory request.
- Cycle counts with Valid returned in the first wait cycle:
  - ALU: 6 cycles.
  - Load: 7 cycles.
  - Store: 7 cycles.
  - Branch: 6 cycles.
  - Branch with link: 7 cycles.

Test Plan:
- Reset held 3 cycles, then released -> fetch=1, wrAdd=1 in the first post-reset cycle; all other outputs 0.
- instr=0x0062_0000 (ALU reg-reg, A=3, B=2), Valid in the first FETCH_W cycle -> strobe sequence: INC (increment, PCEn), then EXEC (wrData, literalEn=0, oppA=3, oppB=2), then WB (regEn). Next fetch begins 6 cycles after the first.
- instr=0xC020_FFFC (immediate, imm=-4) -> literal=0xFFFF_FFFC, literalEn=1 in EXEC.
- Load (IR[31:26]=0x20) with Valid delayed 5 cycles in LOAD_W -> mem_rd held 5 cycles; wrData pulses only in the Valid cycle; regEn follows one cycle later.
- Store (0x21) -> opcode=0x0F with wrData in SDATA, then DataBus_En=1 and mem_wr=1 until Valid.
- Branch-link (0x11) -> LINK (store_PC=1, regEn=1), then BR (Branch_En=1, literalEn=1, wrData=1), then BR_LD (PCEn=1, store_PC=0).
- TIMEOUT=4 with Valid never asserted in FETCH_W -> bus_err=1 after 4 wait cycles and held.
- HALT (0xFC00_0000) -> halted=1 and held.
- Reset asserted during ERR -> bus_err cleared and state FETCH_A next cycle.
